to_lower_stream: RTL

TO_LOWER_STREAM -- requirements
Module: to_lower_stream

---
 rtl/to_lower_pkg.sv | 24 ++
 rtl/lower_case_map.sv | 19 +
 rtl/to_lower_stream.sv | 113 +++++++++++
 3 files changed

// File: rtl/to_lower_pkg.sv
// Shared constants, FIFO state encoding and entry layout for the lowercase stream converter.
// Entry carries the already-converted byte plus whether conversion changed it.
package to_lower_pkg;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam int         CASE_BIT      = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic       conv;
    logic [7:0] data;
  } entry_t;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
  endfunction

endpackage

// File: rtl/lower_case_map.sv
// Combinational ASCII uppercase-to-lowercase map; zero latency, no flow control.
// Only 'A'..'Z' are touched; every other byte passes through unchanged.
module lower_case_map
  import to_lower_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       conv
);

  always_comb begin
    conv = is_upper(din);
    dout = din;
    if (conv) begin
      dout[CASE_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/to_lower_stream.sv
// Valid/ready byte stream that lowercases ASCII letters through a 2-entry FIFO.
// Latency 1 cycle; in_ready drops only when both entries are full, so it never depends on out_ready.
module to_lower_stream
  import to_lower_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_conv,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conv_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fifo_state_e state, state_nxt;
  entry_t      head_q, tail_q;
  entry_t      mapped;
  logic [7:0]  map_data;
  logic        map_conv;
  logic        push, pop;

  lower_case_map u_map (
    .din  (in_data),
    .dout (map_data),
    .conv (map_conv)
  );

  assign mapped = '{conv: map_conv, data: map_data};
  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop) begin
          state_nxt = TWO;
        end else if (pop && !push) begin
          state_nxt = EMPTY;
        end
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs come from the state register alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      EMPTY: in_ready = 1'b1;
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      TWO:     out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // head_q is always the oldest entry; tail_q only matters in TWO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head_q <= mapped;
        ONE: begin
          if (push && pop) begin
            head_q <= mapped;
          end else if (push) begin
            tail_q <= mapped;
          end
        end
        TWO:     if (pop) head_q <= tail_q;
        default: head_q <= head_q;
      endcase
    end
  end

  assign out_data = head_q.data;
  assign out_conv = head_q.conv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt <= '0;
    end else if (cnt_clr) begin
      conv_cnt <= '0;
    end else if (push && mapped.conv && (conv_cnt != CNT_MAX)) begin
      conv_cnt <= conv_cnt + CNT_W'(1);
    end
  end

endmodule
